// File: rtl/udp_frame_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : udp_frame_fifo                                                  |
// | Purpose  : store-and-forward byte FIFO; replays only complete frames on a  |
// |            valid/ready/last stream and drops malformed or oversize frames. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module udp_frame_fifo #(
  parameter int AW        = 11,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_sof,
  input  logic        in_vld,
  input  logic [7:0]  in_data,
  input  logic        in_eof,
  output logic        in_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);
  localparam int              c_depth   = 2 ** AW;
  localparam int              c_lw      = $clog2(MAX_FRAME + 1);
  localparam logic [AW:0]     c_cap     = {1'b1, {AW{1'b0}}};
  localparam logic [c_lw-1:0] c_max_len = c_lw'(MAX_FRAME);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW:0]     r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [AW:0]     w_wr_ptr_nxt, w_commit_nxt, w_used, w_free;
  logic [c_lw-1:0] r_len, w_len_nxt;
  logic [15:0]     r_frame_cnt, r_drop_cnt, w_frame_nxt, w_drop_nxt, w_drop_sat;
  logic            w_we, r_live;
  logic [8:0]      r_mem [c_depth];

  logic            w_pop, w_issue, w_load;
  logic [2:0]      w_occ;
  logic            r_ram_vld;
  logic [8:0]      r_ram_q, r_skid0, r_skid1;
  logic [1:0]      r_skid_cnt;
  logic            r_m_valid, r_m_last;
  logic [7:0]      r_m_data;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_free     = c_cap - w_used;
  assign w_drop_sat = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : r_drop_cnt + 16'd1;
  // Two-slot threshold covers the byte upstream may already have in flight.
  assign in_ready   = r_live & ((r_state == S_DROP) | (w_free >= (AW+1)'(2)));

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_wr_commit;
    w_len_nxt    = r_len;
    w_frame_nxt  = r_frame_cnt;
    w_drop_nxt   = r_drop_cnt;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_sof) begin
          w_state_nxt = S_RECV;
          w_len_nxt   = '0;
        end
      end
      S_RECV: begin
        if (in_sof) begin
          w_wr_ptr_nxt = r_wr_commit;
          w_drop_nxt   = w_drop_sat;
          w_len_nxt    = '0;
        end else if (in_vld) begin
          if (w_free == '0 || r_len == c_max_len) begin
            if (in_eof) begin
              w_wr_ptr_nxt = r_wr_commit;
              w_drop_nxt   = w_drop_sat;
              w_state_nxt  = S_IDLE;
            end else begin
              w_state_nxt  = S_DROP;
            end
          end else begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            w_len_nxt    = r_len + 1'b1;
            if (in_eof) begin
              w_commit_nxt = r_wr_ptr + 1'b1;
              w_frame_nxt  = r_frame_cnt + 16'd1;
              w_state_nxt  = S_IDLE;
            end
          end
        end
      end
      S_DROP: begin
        if (in_sof) begin
          w_wr_ptr_nxt = r_wr_commit;
          w_drop_nxt   = w_drop_sat;
          w_len_nxt    = '0;
          w_state_nxt  = S_RECV;
        end else if (in_vld && in_eof) begin
          w_wr_ptr_nxt = r_wr_commit;
          w_drop_nxt   = w_drop_sat;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_len       <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_wr_commit <= w_commit_nxt;
      r_len       <= w_len_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_drop_cnt  <= w_drop_nxt;
      r_live      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= {in_eof, in_data};
  end

  // Read side: RAM stage + 2-entry skid + output register hold at most 3 bytes.
  assign w_pop   = r_m_valid & m_ready;
  assign w_occ   = {2'b00, r_ram_vld} + {1'b0, r_skid_cnt} + {2'b00, r_m_valid};
  assign w_issue = (r_rd_ptr != r_wr_commit) && ((w_occ - {2'b00, w_pop}) < 3'd3);
  assign w_load  = (r_skid_cnt != 2'd0) && (!r_m_valid || m_ready);

  always_ff @(posedge clk) begin
    if (w_issue) r_ram_q <= r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_ram_vld  <= 1'b0;
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_skid_cnt <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
    end else begin
      r_ram_vld <= w_issue;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({r_ram_vld, w_load})
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid0 <= r_ram_q;
          else                    r_skid1 <= r_ram_q;
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= r_ram_q;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= r_ram_q;
          end
        end
        default: ;
      endcase
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_last  <= r_skid0[8];
        r_m_data  <= r_skid0[7:0];
      end else if (w_pop) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
